// File: rtl/mc10_bus_pkg.sv
// Shared types and address map for the MC-10 external bus responder
// and the video fetch logic.
package mc10_bus_pkg;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_RAM,
        REG_IO,
        REG_ROM
    } bus_region_t;

    typedef enum logic [0:0] {
        RESP_IDLE,
        RESP_WAIT
    } resp_state_t;

    localparam logic [15:0] RAM_BASE  = 16'h4000;
    localparam logic [15:0] RAM_LIMIT = 16'h4FFF;
    localparam logic [15:0] IO_BASE   = 16'hBF00;
    localparam logic [15:0] IO_LIMIT  = 16'hBFFF;
    localparam logic [15:0] ROM_BASE  = 16'hE000;

    function automatic logic is_mem(input bus_region_t r);
        return (r == REG_RAM) || (r == REG_ROM);
    endfunction

endpackage

// File: rtl/mc10_addr_decode.sv
// Combinational CPU address to bus region decoder.
// ROM runs to the top of the address space, so it has no upper bound check.
module mc10_addr_decode
    import mc10_bus_pkg::*;
(
    input  logic [15:0] addr_i,
    output bus_region_t region_o
);

    always_comb begin
        region_o = REG_NONE;
        unique case (1'b1)
            (addr_i >= RAM_BASE) && (addr_i <= RAM_LIMIT): region_o = REG_RAM;
            (addr_i >= IO_BASE) && (addr_i <= IO_LIMIT):   region_o = REG_IO;
            (addr_i >= ROM_BASE):                          region_o = REG_ROM;
            default:                                       region_o = REG_NONE;
        endcase
    end

endmodule

// File: rtl/mc10_bus_responder.sv
// MC-10 bus responder: region decode, wait-state hold, SRAM port, I/O latch.
// Define MC10_IO_LATCH_EN to decode $BFxx and implement the io_latch register.
module mc10_bus_responder
    import mc10_bus_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vma,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  data_out,
    output logic [7:0]  data_in,
    output logic        hold,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_latch
);

    localparam bit          HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0]  WS_LOAD  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    resp_state_t state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    bus_region_t raw_region, region;
    logic        last;
    logic        io_wr;
    logic [7:0]  io_rd;

    mc10_addr_decode u_dec (
        .addr_i   (addr),
        .region_o (raw_region)
    );

`ifdef MC10_IO_LATCH_EN
    assign region = raw_region;
    assign io_rd  = io_in;
`else
    assign region = (raw_region == REG_IO) ? REG_NONE : raw_region;
    assign io_rd  = 8'hFF;
`endif

    assign mem_addr  = addr;
    assign mem_wdata = data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESP_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Gated by rst_n so hold and strobes fall the instant reset asserts.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hold    = 1'b0;
        data_in = 8'hFF;
        mem_oe  = 1'b0;
        mem_we  = 1'b0;
        io_wr   = 1'b0;
        last    = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                RESP_IDLE: begin
                    if (vma && is_mem(region)) begin
                        mem_oe = rw;
                        if (HAS_WAIT) begin
                            hold    = 1'b1;
                            state_d = RESP_WAIT;
                            wcnt_d  = WS_LOAD;
                        end else begin
                            last = 1'b1;
                        end
                    end else if (vma && (region == REG_IO)) begin
                        if (rw) data_in = io_rd;
                        else    io_wr   = 1'b1;
                    end
                end
                RESP_WAIT: begin
                    mem_oe = rw;
                    if (wcnt_q == 4'd0) begin
                        last    = 1'b1;
                        state_d = RESP_IDLE;
                    end else begin
                        hold   = 1'b1;
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
                default: state_d = RESP_IDLE;
            endcase
            if (last) begin
                if (rw)                     data_in = mem_rdata;
                else if (region == REG_RAM) mem_we  = 1'b1;
            end
        end
    end

`ifdef MC10_IO_LATCH_EN
    logic [7:0] io_latch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     io_latch_q <= 8'h00;
        else if (io_wr) io_latch_q <= data_out;
    end

    assign io_latch = io_latch_q;
`else
    logic unused_io;
    assign unused_io = ^{io_in, io_wr, io_rd};
    assign io_latch  = 8'h00;
`endif

endmodule

// File: tb/tb_mc10_bus_responder.sv
// Scoreboard bench: three responders (0, 2 and 3 wait states) on shared inputs.
module tb_mc10_bus_responder;
    import mc10_bus_pkg::*;

    typedef struct packed {
        logic       hold;
        logic [7:0] din;
        logic       oe;
        logic       we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vma = 1'b0;
    logic        rw = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  io_in = 8'h00;

    logic [7:0]  din_w [3];
    logic        hold_w [3];
    logic [15:0] maddr_w [3];
    logic [7:0]  mwd_w [3];
    logic        oe_w [3];
    logic        we_w [3];
    logic [7:0]  lat_w [3];

    exp_t sbq[$];
    int   sel = 1;
    exp_t obs;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mc10_bus_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .vma(vma), .rw(rw), .addr(addr),
        .data_out(data_out), .data_in(din_w[0]), .hold(hold_w[0]),
        .mem_addr(maddr_w[0]), .mem_wdata(mwd_w[0]), .mem_rdata(mem_rdata),
        .mem_oe(oe_w[0]), .mem_we(we_w[0]), .io_in(io_in), .io_latch(lat_w[0])
    );

    mc10_bus_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst_n(rst_n), .vma(vma), .rw(rw), .addr(addr),
        .data_out(data_out), .data_in(din_w[1]), .hold(hold_w[1]),
        .mem_addr(maddr_w[1]), .mem_wdata(mwd_w[1]), .mem_rdata(mem_rdata),
        .mem_oe(oe_w[1]), .mem_we(we_w[1]), .io_in(io_in), .io_latch(lat_w[1])
    );

    mc10_bus_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .vma(vma), .rw(rw), .addr(addr),
        .data_out(data_out), .data_in(din_w[2]), .hold(hold_w[2]),
        .mem_addr(maddr_w[2]), .mem_wdata(mwd_w[2]), .mem_rdata(mem_rdata),
        .mem_oe(oe_w[2]), .mem_we(we_w[2]), .io_in(io_in), .io_latch(lat_w[2])
    );

    always_comb obs = '{hold_w[sel], din_w[sel], oe_w[sel], we_w[sel]};

    task automatic idle(input int n);
        vma = 1'b0;
        rw  = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
`ifdef MC10_IO_LATCH_EN
        logic [7:0] pre = 8'h5A;
`else
        logic [7:0] pre = 8'h00;
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        vma = 1'b1; rw = 1'b0; addr = 16'hBF00; data_out = 8'h5A;
        @(posedge clk); #1;
        vma = 1'b0;
        n_chk++;
        if (lat_w[1] !== pre) begin
            n_fail++;
            $display("FAIL reset_pre_latch got %h exp %h", lat_w[1], pre);
        end
        vma = 1'b1; rw = 1'b1; addr = 16'h4010; rst_n = 1'b0;
        #1;
        n_chk++;
        if (lat_w[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_latch got %h exp 00", lat_w[1]);
        end
        for (int i = 0; i < 3; i++) sbq.push_back('{1'b0, 8'hFF, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_out dut%0d got %h exp %h", i, obs, e);
            end
        end
        sel = 1;
        @(posedge clk); #1;
        vma = 1'b0;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_ram_read();
        exp_t e;
        sel = 1;
        vma = 1'b1; rw = 1'b1; addr = 16'h4010; mem_rdata = 8'h3C;
        sbq.push_back('{1'b1, 8'hFF, 1'b1, 1'b0});
        sbq.push_back('{1'b1, 8'hFF, 1'b1, 1'b0});
        sbq.push_back('{1'b0, 8'h3C, 1'b1, 1'b0});
        sbq.push_back('{1'b0, 8'hFF, 1'b0, 1'b0});
        for (int c = 0; c < 4; c++) begin
            if (c == 3) vma = 1'b0;
            @(negedge clk);
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL ram_read c%0d got %h exp %h", c, obs, e);
            end
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sel = 1;
        vma = 1'b1; rw = 1'b0; addr = 16'h4FFF; data_out = 8'hA5;
        for (int c = 0; c < 6; c++)
            sbq.push_back('{(c % 3) != 2, 8'hFF, 1'b0, c == 2});
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                addr = 16'hF000; data_out = 8'h77;
            end
            @(negedge clk);
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL b2b_write c%0d got %h exp %h", c, obs, e);
            end
            if (c == 2) begin
                n_chk++;
                if (mwd_w[1] !== 8'hA5 || maddr_w[1] !== 16'h4FFF) begin
                    n_fail++;
                    $display("FAIL ram_wdata got %h@%h exp a5@4fff", mwd_w[1], maddr_w[1]);
                end
            end
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_io();
        exp_t e;
`ifdef MC10_IO_LATCH_EN
        logic [7:0] lat_x = 8'h20;
        logic [7:0] din_x = 8'h7E;
`else
        logic [7:0] lat_x = 8'h00;
        logic [7:0] din_x = 8'hFF;
`endif
        sel = 1;
        vma = 1'b1; rw = 1'b0; addr = 16'hBFFF; data_out = 8'h20; io_in = 8'h7E;
        sbq.push_back('{1'b0, 8'hFF, 1'b0, 1'b0});
        sbq.push_back('{1'b0, din_x, 1'b0, 1'b0});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL io c%0d got %h exp %h", c, obs, e);
            end
            @(posedge clk); #1;
            if (c == 0) begin
                n_chk++;
                if (lat_w[1] !== lat_x) begin
                    n_fail++;
                    $display("FAIL io_latch got %h exp %h", lat_w[1], lat_x);
                end
                rw = 1'b1;
            end
        end
        idle(4);
    endtask

    task automatic test_unmapped_ws0();
        exp_t e;
        vma = 1'b1; rw = 1'b1; addr = 16'h8000; mem_rdata = 8'h99;
        sel = 1;
        sbq.push_back('{1'b0, 8'hFF, 1'b0, 1'b0});
        @(negedge clk);
        e = sbq.pop_front();
        n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL unmapped got %h exp %h", obs, e);
        end
        @(posedge clk); #1;
        addr = 16'hE000; sel = 0;
        sbq.push_back('{1'b0, 8'h99, 1'b1, 1'b0});
        @(negedge clk);
        e = sbq.pop_front();
        n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL ws0_rom got %h exp %h", obs, e);
        end
        @(posedge clk); #1;
        sel = 1;
        idle(4);
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        int   we_seen = 0;
        sel = 2;
        vma = 1'b1; rw = 1'b0; addr = 16'h4000; data_out = 8'h11;
        sbq.push_back('{1'b1, 8'hFF, 1'b0, 1'b0});
        sbq.push_back('{1'b1, 8'hFF, 1'b0, 1'b0});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rst_mid pre c%0d got %h exp %h", c, obs, e);
            end
            if (c == 0) begin
                @(posedge clk); #1;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (hold_w[2] !== 1'b0 || we_w[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_drop got hold=%b we=%b exp 0 0", hold_w[2], we_w[2]);
        end
        @(posedge clk); #1;
        vma = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (we_w[2] !== 1'b0 || hold_w[2] !== 1'b0) we_seen++;
            @(posedge clk); #1;
        end
        n_chk++;
        if (we_seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet got %0d active cycles exp 0", we_seen);
        end
        vma = 1'b1; rw = 1'b1; addr = 16'h4000; mem_rdata = 8'hC3;
        for (int c = 0; c < 4; c++)
            sbq.push_back('{c != 3, (c == 3) ? 8'hC3 : 8'hFF, 1'b1, 1'b0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rst_mid_after c%0d got %h exp %h", c, obs, e);
            end
            @(posedge clk); #1;
        end
        sel = 1;
        idle(4);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ram_read();
        test_back_to_back();
        test_io();
        test_unmapped_ws0();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
